// File: rtl/aib_rx_align_pkg.sv
// Shared types and constants for the AIB receive word aligner.
package aib_rx_align_pkg;

  // Per-lane alignment state.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

  // Default marker field: two bits at the top of every aligned word.
  localparam int         DEF_MARK_W   = 2;
  localparam logic [1:0] DEF_MARK_VAL = 2'b10;

  // LSB position of channel `ch` inside a flat bus of `width`-bit slices.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/aib_rx_word_align_lane.sv
// One receive channel: bit-slip search for the marker, lock hysteresis,
// realigned output register and bypass handling.
module aib_rx_word_align_lane
  import aib_rx_align_pkg::*;
#(
  parameter int                W          = 40,
  parameter int                MARK_W     = DEF_MARK_W,
  parameter logic [MARK_W-1:0] MARK_VAL   = MARK_W'(DEF_MARK_VAL),
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bypass,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 locked,
  output logic                 locked_nxt,
  output logic [$clog2(W)-1:0] offset
);

  localparam int OFF_W  = $clog2(W);
  localparam int MCNT_W = $clog2(LOCK_CNT + 1);
  localparam int XCNT_W = $clog2(UNLOCK_CNT + 1);

  align_state_e      state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [MCNT_W-1:0] match_q, match_d;
  logic [XCNT_W-1:0] miss_q, miss_d;
  logic [W-1:0]      prev_q, prev_d;
  logic [W-1:0]      data_q, data_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;

  logic [2*W-1:0]    window_s;
  logic [W-1:0]      cand_s;
  logic              hit_s;
  logic [OFF_W-1:0]  slip_s;
  logic [MCNT_W-1:0] match_inc_s;
  logic [XCNT_W-1:0] miss_inc_s;

  // Candidate word at the current offset, marker test and incremented values.
  always_comb begin
    window_s    = {in_data, prev_q};
    cand_s      = window_s[offset_q +: W];
    hit_s       = (cand_s[W-1 -: MARK_W] == MARK_VAL);
    slip_s      = (offset_q == OFF_W'(W - 1)) ? {OFF_W{1'b0}} : offset_q + OFF_W'(1);
    match_inc_s = match_q + MCNT_W'(1);
    miss_inc_s  = miss_q + XCNT_W'(1);
  end

  // Next-state: bypass override, then search/lock FSM on valid words only.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    match_d  = match_q;
    miss_d   = miss_q;
    prev_d   = prev_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    locked_d = (state_q == LOCKED);
    if (bypass) begin
      // Offset 0 means the candidate is simply the previous word.
      state_d  = SEARCH;
      offset_d = {OFF_W{1'b0}};
      match_d  = {MCNT_W{1'b0}};
      miss_d   = {XCNT_W{1'b0}};
      if (in_valid) begin
        prev_d = in_data;
        data_d = prev_q;
      end else begin
        prev_d = prev_q;
        data_d = data_q;
      end
      valid_d  = in_valid;
      locked_d = 1'b1;
    end else if (in_valid) begin
      prev_d = in_data;
      data_d = cand_s;
      case (state_q)
        SEARCH: begin
          if (hit_s) begin
            if (match_inc_s == MCNT_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              match_d = {MCNT_W{1'b0}};
              miss_d  = {XCNT_W{1'b0}};
            end else begin
              match_d = match_inc_s;
            end
          end else begin
            match_d  = {MCNT_W{1'b0}};
            offset_d = slip_s;
          end
        end
        LOCKED: begin
          if (hit_s) begin
            miss_d = {XCNT_W{1'b0}};
          end else if (miss_inc_s == XCNT_W'(UNLOCK_CNT)) begin
            // Drop lock and resume searching one bit further on.
            state_d  = SEARCH;
            miss_d   = {XCNT_W{1'b0}};
            match_d  = {MCNT_W{1'b0}};
            offset_d = slip_s;
          end else begin
            miss_d = miss_inc_s;
          end
        end
        default: begin
          state_d = SEARCH;
          match_d = {MCNT_W{1'b0}};
          miss_d  = {XCNT_W{1'b0}};
        end
      endcase
      // The locking word is forwarded; the unlocking word is not.
      valid_d  = (state_d == LOCKED);
      locked_d = (state_d == LOCKED);
    end else begin
      valid_d  = 1'b0;
      locked_d = (state_q == LOCKED);
    end
  end

  // State, datapath history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      offset_q <= {OFF_W{1'b0}};
      match_q  <= {MCNT_W{1'b0}};
      miss_q   <= {XCNT_W{1'b0}};
      prev_q   <= {W{1'b0}};
      data_q   <= {W{1'b0}};
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign locked     = locked_q;
  assign locked_nxt = locked_d;
  assign offset     = offset_q;

endmodule

// File: rtl/aib_rx_word_align.sv
// Multi-channel AIB receive word aligner: one independent lane per channel
// plus a registered all-channels-locked summary.
module aib_rx_word_align
  import aib_rx_align_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                W          = 40,
  parameter int                MARK_W     = DEF_MARK_W,
  parameter logic [MARK_W-1:0] MARK_VAL   = MARK_W'(DEF_MARK_VAL),
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 3
) (
  input  logic                           i_bus_clk,
  input  logic                           i_rst,
  input  logic                           c_bypass_word_align,
  input  logic [NUM_CH-1:0]              i_rx_valid,
  input  logic [NUM_CH*W-1:0]            i_rx_data,
  output logic [NUM_CH-1:0]              o_rx_valid,
  output logic [NUM_CH*W-1:0]            o_rx_data,
  output logic [NUM_CH-1:0]              o_locked,
  output logic                           o_all_locked,
  output logic [NUM_CH*$clog2(W)-1:0]    o_offset
);

  localparam int OFF_W = $clog2(W);

  logic [NUM_CH-1:0] locked_nxt_s;
  logic              all_locked_q, all_locked_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    aib_rx_word_align_lane #(
      .W         (W),
      .MARK_W    (MARK_W),
      .MARK_VAL  (MARK_VAL),
      .LOCK_CNT  (LOCK_CNT),
      .UNLOCK_CNT(UNLOCK_CNT)
    ) u_lane (
      .clk       (i_bus_clk),
      .rst       (i_rst),
      .bypass    (c_bypass_word_align),
      .in_valid  (i_rx_valid[c]),
      .in_data   (i_rx_data[ch_lsb(c, W) +: W]),
      .out_valid (o_rx_valid[c]),
      .out_data  (o_rx_data[ch_lsb(c, W) +: W]),
      .locked    (o_locked[c]),
      .locked_nxt(locked_nxt_s[c]),
      .offset    (o_offset[ch_lsb(c, OFF_W) +: OFF_W])
    );
  end

  // Summary lock uses next-cycle lane lock so it lines up with o_locked.
  always_comb begin
    all_locked_d = &locked_nxt_s;
  end

  // Registered all-locked flag.
  always_ff @(posedge i_bus_clk or posedge i_rst) begin
    if (i_rst) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= all_locked_d;
    end
  end

  assign o_all_locked = all_locked_q;

endmodule

// File: tb/tb_aib_rx_word_align.sv
// Randomised self-checking bench for aib_rx_word_align with a word-level
// reference model of the marker search / lock rules.
module tb_aib_rx_word_align;

  localparam int NUM_CH     = 2;
  localparam int W          = 40;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int OW         = $clog2(W);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  byp;
  logic [NUM_CH-1:0]     iv;
  logic [NUM_CH*W-1:0]   id;
  logic [NUM_CH-1:0]     o_rx_valid;
  logic [NUM_CH*W-1:0]   o_rx_data;
  logic [NUM_CH-1:0]     o_locked;
  logic                  o_all_locked;
  logic [NUM_CH*OW-1:0]  o_offset;

  always #5 clk = ~clk;

  aib_rx_word_align #(
    .NUM_CH    (NUM_CH),
    .W         (W),
    .MARK_W    (2),
    .MARK_VAL  (2'b10),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .i_bus_clk          (clk),
    .i_rst              (rst),
    .c_bypass_word_align(byp),
    .i_rx_valid         (iv),
    .i_rx_data          (id),
    .o_rx_valid         (o_rx_valid),
    .o_rx_data          (o_rx_data),
    .o_locked           (o_locked),
    .o_all_locked       (o_all_locked),
    .o_offset           (o_offset)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] m_prev  [NUM_CH];
  int           m_off   [NUM_CH];
  bit           m_lock  [NUM_CH];
  int           m_match [NUM_CH];
  int           m_miss  [NUM_CH];
  logic [W-1:0] e_data  [NUM_CH];
  bit           e_valid [NUM_CH];
  bit           e_locked[NUM_CH];
  bit           e_all;

  // Stream generator state: next aligned word and true bit offset
  logic [W-1:0] g_next[NUM_CH];
  int           g_t   [NUM_CH];
  bit           g_zero[NUM_CH];

  task automatic chk(input string nm, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d actual=%h expected=%h t=%0t", nm, c, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_prev[c] = '0; m_off[c] = 0; m_lock[c] = 0; m_match[c] = 0; m_miss[c] = 0;
      e_data[c] = '0; e_valid[c] = 0; e_locked[c] = 0;
    end
    e_all = 0;
  endtask

  task automatic model_step();
    logic [2*W-1:0] win;
    logic [W-1:0]   cand;
    bit             hit;
    for (int c = 0; c < NUM_CH; c++) begin
      if (byp) begin
        if (iv[c]) begin
          e_data[c] = m_prev[c];
          m_prev[c] = id[c*W +: W];
        end
        e_valid[c] = iv[c]; e_locked[c] = 1;
        m_lock[c] = 0; m_off[c] = 0; m_match[c] = 0; m_miss[c] = 0;
      end else if (iv[c]) begin
        win  = {id[c*W +: W], m_prev[c]};
        cand = W'(win >> m_off[c]);
        hit  = (cand[W-1 -: 2] == 2'b10);
        m_prev[c] = id[c*W +: W];
        e_data[c] = cand;
        if (!m_lock[c]) begin
          if (hit) begin
            m_match[c]++;
            if (m_match[c] == LOCK_CNT) begin
              m_lock[c] = 1; m_match[c] = 0; m_miss[c] = 0;
            end
          end else begin
            m_match[c] = 0;
            m_off[c] = (m_off[c] + 1) % W;
          end
        end else begin
          if (hit) m_miss[c] = 0;
          else begin
            m_miss[c]++;
            if (m_miss[c] == UNLOCK_CNT) begin
              m_lock[c] = 0; m_miss[c] = 0; m_match[c] = 0;
              m_off[c] = (m_off[c] + 1) % W;
            end
          end
        end
        e_valid[c] = m_lock[c]; e_locked[c] = m_lock[c];
      end else begin
        e_valid[c] = 0; e_locked[c] = m_lock[c];
      end
    end
    e_all = 1;
    for (int c = 0; c < NUM_CH; c++) e_all = e_all & e_locked[c];
  endtask

  task automatic compare();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("rx_valid", c, W'(o_rx_valid[c]), W'(e_valid[c]));
      chk("locked",   c, W'(o_locked[c]),   W'(e_locked[c]));
      chk("offset",   c, W'(o_offset[c*OW +: OW]), W'(m_off[c]));
      if (e_valid[c]) chk("rx_data", c, o_rx_data[c*W +: W], e_data[c]);
    end
    chk("all_locked", -1, W'(o_all_locked), W'(e_all));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare();
  endtask

  // Raw word whose window at offset g_t holds the current aligned word.
  task automatic gen_word(input int c, input bit bad, output logic [W-1:0] raw);
    logic [W-1:0]   cur, nxt;
    logic [2*W-1:0] cat;
    cur = g_next[c];
    nxt = g_zero[c] ? '0 : W'({$urandom, $urandom});
    nxt[W-1 -: 2] = bad ? 2'b01 : 2'b10;
    g_next[c] = nxt;
    cat = {nxt, cur};
    raw = W'(cat >> (W - g_t[c]));
  endtask

  task automatic drive(input bit v0, input bit v1, input bit b0, input bit b1);
    logic [W-1:0] raw;
    bit v[NUM_CH];
    bit b[NUM_CH];
    v[0] = v0; v[1] = v1; b[0] = b0; b[1] = b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c]) gen_word(c, b[c], raw);
      else raw = W'({$urandom, $urandom});
      iv[c] = v[c];
      id[c*W +: W] = raw;
    end
  endtask

  task automatic step(input bit v0, input bit v1, input bit b0, input bit b1);
    drive(v0, v1, b0, b1);
    tick();
  endtask

  task automatic restart(input int t0, input int t1, input bit zero);
    rst = 1'b1; iv = '0;
    tick(); tick();
    g_t[0] = t0; g_t[1] = t1;
    for (int c = 0; c < NUM_CH; c++) begin
      g_zero[c] = zero;
      g_next[c] = {2'b10, {(W-2){1'b0}}};
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; byp = 1'b0; iv = '0; id = '0;
    model_reset();
    tick();
    chk("reset_locked", -1, W'(o_locked), W'(0));

    // Zero-payload streams, ch0 true offset 7, ch1 true offset 39
    restart(7, 39, 1'b1);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 0);
    chk("ch0_off_before_lock", 0, W'(o_offset[0 +: OW]), W'(7));
    chk("ch0_not_yet_locked", 0, W'(o_locked[0]), W'(0));
    step(1, 1, 0, 0);
    chk("ch0_lock_on_4th_hit", 0, W'(o_locked[0]), W'(1));
    for (int k = 0; k < 44; k++) step(1, 1, 0, 0);
    chk("ch1_off_39", 1, W'(o_offset[OW +: OW]), W'(39));
    chk("all_locked_lit", -1, W'(o_all_locked), W'(1));
    chk("ch0_marker", 0, W'(o_rx_data[W-1 -: 2]), W'(2'b10));

    // Two bad markers then good: lock holds
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
    chk("ch0_still_locked", 0, W'(o_locked[0]), W'(1));
    chk("ch0_off_held", 0, W'(o_offset[0 +: OW]), W'(7));

    // Three bad markers: unlock and slip to 8
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    chk("ch0_unlocked", 0, W'(o_locked[0]), W'(0));
    chk("ch0_unlock_word_dropped", 0, W'(o_rx_valid[0]), W'(0));
    chk("ch0_off_8", 0, W'(o_offset[0 +: OW]), W'(8));
    chk("ch1_unaffected", 1, W'(o_locked[1]), W'(1));
    chk("all_locked_drop", -1, W'(o_all_locked), W'(0));

    // ch1 unlock at offset 39 wraps to 0, then both relock
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    chk("ch1_wrap_0", 1, W'(o_offset[OW +: OW]), W'(0));
    for (int k = 0; k < 90; k++) step(1, 1, 0, 0);
    chk("ch1_relock_39", 1, W'(o_offset[OW +: OW]), W'(39));
    chk("both_relocked", -1, W'(o_locked), W'(2'b11));

    // Mid-search hold with ch0 invalid and data toggling
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0);

    // Offsets 5 and 20 with random valid gaps
    restart(5, 20, 1'b1);
    for (int k = 0; k < 120; k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 0, 0);

    // Fully random payloads, offsets and marker corruption
    for (int r = 0; r < 3; r++) begin
      restart($urandom_range(0, W-1), $urandom_range(0, W-1), 1'b0);
      for (int k = 0; k < 150; k++)
        step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    // Bypass then release back into search
    byp = 1'b1;
    for (int k = 0; k < 40; k++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);
    chk("bypass_locked", -1, W'(o_locked), W'(2'b11));
    byp = 1'b0;
    for (int k = 0; k < 60; k++) step(1, 1, 0, 0);

    // Reset asserted mid-lock clears outputs immediately
    restart(7, 39, 1'b1);
    for (int k = 0; k < 55; k++) step(1, 1, 0, 0);
    chk("pre_reset_locked", -1, W'(o_locked), W'(2'b11));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rx_valid", -1, W'(o_rx_valid), W'(0));
    chk("rst_locked", -1, W'(o_locked), W'(0));
    chk("rst_all_locked", -1, W'(o_all_locked), W'(0));
    chk("rst_offset", -1, W'(o_offset), W'(0));
    chk("rst_data0", 0, o_rx_data[0 +: W], W'(0));
    compare();
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
